conv_kernel_loader: RTL
=======================

CONV_KERNEL_LOADER -- requirements
Module: conv_kernel_loader

Interface
REQ-001 The block SHALL have parameters: WIDTH 32, data word width; KERNEL_SIZE 3, kernel edge (9 taps); TOTAL_WEIGHT 4, number of kernels; ADDR_WIDTH 6, weight ROM address width.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  0 stalls new ROM reads; in-flight read still completes
- cmd  in  2  0 IDLE, 1 LOAD_KERNEL, 2 LOAD_BIAS, 3 ABORT
- kernel_sel  in  2  kernel index, sampled with cmd
- rom_rd_en  out  1  weight ROM read strobe
- rom_addr  out  ADDR_WIDTH  weight ROM address
- rom_data  in  WIDTH  ROM data, valid 1 cycle after rom_rd_en
- kernel_wr_en  out  1  kernel array tap write strobe
- kernel_wr_idx  out  4  tap index 0..8, row-major
- kernel_wr_data  out  WIDTH  tap value, equal to rom_data
- bias_wr_en  out  1  bias register write strobe
- bias_wr_data  out  WIDTH  bias value, equal to rom_data
- ack  out  2  0 IDLE, 1 KERNEL_FIN, 2 BIAS_FIN, 3 ABORTED
- busy  out  1  high from the cycle after acceptance until the ack cycle, inclusive

Function
REQ-003 ROM map SHALL be: kernel k taps at k*9..k*9+8; bias k at 36+k.
REQ-004 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-005 In IDLE with enable=1, cmd 1 or 2 SHALL be accepted at the clock edge, latching kernel_sel; the FSM then goes to FETCH.
REQ-006 In IDLE, cmd 0 or 3, or any cmd while enable=0, SHALL be ignored.
REQ-007 In FETCH for LOAD_KERNEL, the block SHALL assert rom_rd_en in each enabled cycle with rom_addr = base + tap counter; the counter runs 0..8 and advances only when rom_rd_en=1.
REQ-008 In FETCH for LOAD_BIAS, the block SHALL issue exactly one read at address 36+kernel_sel.
REQ-009 When enable=0 in FETCH, rom_rd_en SHALL be 0, and rom_addr and the counter SHALL hold.
REQ-010 kernel_wr_en (kernel load) or bias_wr_en (bias load) SHALL assert exactly 1 cycle after each rom_rd_en; kernel_wr_idx SHALL equal the counter value issued with that read.
REQ-011 After the last read issues, the FSM SHALL go to DRAIN; after the last write cycle, it SHALL go to DONE.
REQ-012 In DONE, ack SHALL be KERNEL_FIN or BIAS_FIN for exactly 1 cycle, then the FSM SHALL return to IDLE with ack=0 and busy=0.
REQ-013 Unstalled kernel-load timing, with cmd accepted at edge T: reads in cycles T+1..T+9, writes T+2..T+10, ack at T+11.
REQ-014 Unstalled bias-load timing: read at T+1, write at T+2, ack at T+3.
REQ-015 cmd=3 in FETCH or DRAIN SHALL stop new reads from the next cycle; any in-flight write SHALL still complete.
REQ-016 After an abort, ack SHALL be ABORTED for 1 cycle, then the FSM SHALL return to IDLE; no further writes SHALL occur.
REQ-017 cmd 1 or 2 while busy SHALL be ignored and SHALL NOT be queued.
REQ-018 ABORT and the last read in the same cycle SHALL be treated as abort: ack=ABORTED after the final write.
REQ-019 A new cmd SHALL be acceptable in the cycle after DONE, i.e. the first IDLE cycle.
REQ-020 All outputs except kernel_wr_data and bias_wr_data SHALL be registered.
REQ-021 The tap counter SHALL NOT exceed 8; addresses SHALL never exceed 39.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: state IDLE, counters 0, rom_rd_en 0, rom_addr 0, kernel_wr_en 0, kernel_wr_idx 0, bias_wr_en 0, ack 0, busy 0.
REQ-023 Reset mid-load SHALL discard the operation with no further strobes after release; the first cmd SHALL be accepted from the first enabled edge after release.

Verification
REQ-024 Kernel load: cmd=1, kernel_sel=2, enable=1 -> addresses 18..26 at T+1..T+9; writes idx 0..8 carrying rom_data; ack=1 at T+11 only.
REQ-025 Bias load: cmd=2, kernel_sel=3 -> one read at addr 39; bias_wr_en at T+2; ack=2 at T+3.
REQ-026 Stall: enable=0 for 3 cycles after the 4th read (addr 3) -> no reads in those 3 cycles, 4th write still occurs, addr 4 issued on resume, ack delayed 3 cycles to T+14.
REQ-027 Abort: cmd=3 during the 5th read -> the 5th write occurs, no 6th read, ack=3 for 1 cycle, then IDLE.
REQ-028 Busy rejection: cmd=2 during a kernel load -> no bias read; only ack=1 occurs.
REQ-029 Reset: rst_n low at T+5 of a kernel load -> all outputs 0 immediately; after release, cmd=1 kernel_sel=0 performs a full load at addresses 0..8.

Source files
------------

// File: rtl/conv_kernel_loader.sv
// Convolution kernel/bias loader: streams a 3x3 kernel or one bias word from the
// weight ROM into the kernel array / bias register, with stall and abort support.
module conv_kernel_loader #(
    parameter int WIDTH        = 32,
    parameter int KERNEL_SIZE  = 3,
    parameter int TOTAL_WEIGHT = 4,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            cmd,
    input  logic [1:0]            kernel_sel,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    output logic                  kernel_wr_en,
    output logic [3:0]            kernel_wr_idx,
    output logic [WIDTH-1:0]      kernel_wr_data,
    output logic                  bias_wr_en,
    output logic [WIDTH-1:0]      bias_wr_data,
    output logic [1:0]            ack,
    output logic                  busy
);

    localparam int                    TAPS       = KERNEL_SIZE * KERNEL_SIZE;
    localparam logic [3:0]            LAST_TAP   = 4'(TAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] TAP_STRIDE = ADDR_WIDTH'(TAPS);
    localparam logic [ADDR_WIDTH-1:0] BIAS_BASE  = ADDR_WIDTH'(TOTAL_WEIGHT * TAPS);

    localparam logic [1:0] CMD_LOAD_KERNEL = 2'd1;
    localparam logic [1:0] CMD_LOAD_BIAS   = 2'd2;
    localparam logic [1:0] CMD_ABORT       = 2'd3;

    localparam logic [1:0] ACK_IDLE       = 2'd0;
    localparam logic [1:0] ACK_KERNEL_FIN = 2'd1;
    localparam logic [1:0] ACK_BIAS_FIN   = 2'd2;
    localparam logic [1:0] ACK_ABORTED    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            tap, tap_nxt;
    logic                  is_bias, is_bias_nxt;
    logic                  aborted, aborted_nxt;
    logic                  rom_rd_en_nxt;
    logic [ADDR_WIDTH-1:0] rom_addr_nxt;
    logic                  kernel_wr_en_nxt;
    logic [3:0]            kernel_wr_idx_nxt;
    logic                  bias_wr_en_nxt;
    logic [1:0]            ack_nxt;
    logic                  busy_nxt;

    logic accept;
    logic last_issued;
    logic abort_req;

    // The first read is issued on the accepting edge, so FETCH always has a read
    // outstanding or behind it; tap therefore names the most recently issued read.
    assign accept      = (state == S_IDLE) && enable &&
                         ((cmd == CMD_LOAD_KERNEL) || (cmd == CMD_LOAD_BIAS));
    assign last_issued = rom_rd_en && (is_bias || (tap == LAST_TAP));
    assign abort_req   = (cmd == CMD_ABORT);

    assign kernel_wr_data = rom_data;
    assign bias_wr_data   = rom_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_FETCH;
            S_FETCH: if (abort_req || last_issued) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rom_rd_en_nxt     = 1'b0;
        rom_addr_nxt      = rom_addr;
        tap_nxt           = tap;
        is_bias_nxt       = is_bias;
        aborted_nxt       = aborted;
        ack_nxt           = ACK_IDLE;
        busy_nxt          = busy;
        // Each issued read turns into exactly one write on the following cycle,
        // even when an abort is arriving, so in-flight data always lands.
        kernel_wr_en_nxt  = rom_rd_en && !is_bias;
        bias_wr_en_nxt    = rom_rd_en && is_bias;
        kernel_wr_idx_nxt = tap;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    rom_rd_en_nxt = 1'b1;
                    tap_nxt       = 4'd0;
                    is_bias_nxt   = (cmd == CMD_LOAD_BIAS);
                    aborted_nxt   = 1'b0;
                    busy_nxt      = 1'b1;
                    rom_addr_nxt  = (cmd == CMD_LOAD_BIAS)
                                  ? BIAS_BASE + ADDR_WIDTH'(kernel_sel)
                                  : ADDR_WIDTH'(kernel_sel) * TAP_STRIDE;
                end
            end
            S_FETCH: begin
                if (abort_req) begin
                    aborted_nxt = 1'b1;
                end else if (!last_issued && enable) begin
                    rom_rd_en_nxt = 1'b1;
                    tap_nxt       = tap + 4'd1;
                    rom_addr_nxt  = rom_addr + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (abort_req) aborted_nxt = 1'b1;
                if (aborted || abort_req) ack_nxt = ACK_ABORTED;
                else if (is_bias)         ack_nxt = ACK_BIAS_FIN;
                else                      ack_nxt = ACK_KERNEL_FIN;
            end
            S_DONE: begin
                busy_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap           <= 4'd0;
            is_bias       <= 1'b0;
            aborted       <= 1'b0;
            rom_rd_en     <= 1'b0;
            rom_addr      <= '0;
            kernel_wr_en  <= 1'b0;
            kernel_wr_idx <= 4'd0;
            bias_wr_en    <= 1'b0;
            ack           <= ACK_IDLE;
            busy          <= 1'b0;
        end else begin
            tap           <= tap_nxt;
            is_bias       <= is_bias_nxt;
            aborted       <= aborted_nxt;
            rom_rd_en     <= rom_rd_en_nxt;
            rom_addr      <= rom_addr_nxt;
            kernel_wr_en  <= kernel_wr_en_nxt;
            kernel_wr_idx <= kernel_wr_idx_nxt;
            bias_wr_en    <= bias_wr_en_nxt;
            ack           <= ack_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule
